// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Accepts one byte, inhibits the bus, issues request-to-send, shifts the
// byte plus odd parity out on device-generated clock falling edges, then
// checks the device acknowledge and waits for the bus to go idle.
// Optional transfer watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 12000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_e;

    // Inhibit counter runs 0 .. INHIBIT_CYC-1.
    localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);

    // Both counts must describe at least one cycle.
    if (INHIBIT_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("ps2_host_tx: INHIBIT_CYC and TIMEOUT_CYC must be >= 1");
    end

    // Synchronizer and edge-detect flops.
    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;
    logic clk_fe;

    // Control and datapath flops.
    state_e           state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;

    // Registered outputs.
    logic clk_oe_q, clk_oe_d;
    logic data_oe_q, data_oe_d;
    logic tx_ready_q, tx_ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // Two-stage synchronizers on both pads plus a delayed clock copy for edge detection.
    always_comb begin
        clk_meta_d  = ps2_clk_in;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = ps2_data_in;
        data_sync_d = data_meta_q;
        clk_fe      = clk_prev_q & ~clk_sync_q;
    end

    // Next-state and next-output logic for the transfer sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        parity_d  = parity_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        wd_cnt_d  = wd_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    data_d    = tx_data;
                    parity_d  = ~^tx_data;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    // Start bit: pull data low while the clock is still held.
                    data_oe_d = 1'b1;
                    state_d   = ST_RTS;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_cnt_d  = '0;
`endif
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end

            ST_RTS: begin
                // Release the clock so the device starts clocking; keep the start bit.
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
                bit_cnt_d = 4'd0;
                state_d   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (clk_fe) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        // Stop bit is a released line.
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                if (clk_fe) begin
                    if (!data_sync_q) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog covers every device-paced state; it overrides any transition above.
        if (state_q == ST_RTS || state_q == ST_SHIFT ||
            state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
            if (wd_cnt_q == WD_LAST) begin
                done_d  = 1'b0;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end else if (state_q == ST_IDLE) begin
            wd_cnt_d = '0;
        end
`endif

        // Whenever the next state is IDLE both lines are released.
        if (state_d == ST_IDLE) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
        end

        tx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            state_q     <= ST_IDLE;
            inh_cnt_q   <= '0;
            bit_cnt_q   <= 4'd0;
            data_q      <= 8'd0;
            parity_q    <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q    <= '0;
`endif
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            inh_cnt_q   <= inh_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            parity_q    <= parity_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q    <= wd_cnt_d;
`endif
        end
    end

    assign tx_ready    = tx_ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: keyboard model on open-drain lines, random
// command bytes checked against a frame model built from the byte value.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int TMO  = 400;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, err;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    // Wired-AND open-drain bus.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    logic err_prev = 1'b0;
    logic rdy_after_err = 1'b0;
    logic err_clk_oe = 1'b0;
    logic err_data_oe = 1'b0;
    logic [9:0] last_seen;

    // Expected line values after fe 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] line_model(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (err_prev) rdy_after_err = tx_ready;
        err_prev = err;
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
            err_clk_oe = ps2_clk_oe;
            err_data_oe = ps2_data_oe;
        end
        if (done && err) both_cnt++;
    endtask

    task automatic accept(input logic [7:0] b, input bit hold);
        int g = 0;
        while (!tx_ready && g < 50) begin tick(); g++; end
        tx_data = b;
        tx_valid = 1'b1;
        tick();
        if (!hold) tx_valid = 1'b0;
        n_checks++;
        if ({busy, tx_ready, ps2_clk_oe, ps2_data_oe} !== 4'b1010) begin
            n_fail++;
            $display("FAIL accept: busy/ready/clk_oe/data_oe=%b want 1010", {busy, tx_ready, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    // Inhibit length, RTS cycle and clock release; returns the RTS cycle number.
    task automatic phase_start(input bit jitter, output int rts_cyc);
        int inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < INH + 10) begin
            if (jitter) begin
                tx_valid = 1'($urandom_range(0, 1));
                tx_data  = 8'($urandom);
            end
            inh++;
            tick();
        end
        if (jitter) tx_valid = 1'b0;
        n_checks++;
        if (inh !== INH) begin n_fail++; $display("FAIL inhibit_len: got %0d want %0d", inh, INH); end
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
            n_fail++; $display("FAIL rts: clk_oe/data_oe=%b want 11", {ps2_clk_oe, ps2_data_oe});
        end
        rts_cyc = cyc;
        tick();
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
            n_fail++; $display("FAIL shift_entry: clk_oe/data_oe=%b want 01", {ps2_clk_oe, ps2_data_oe});
        end
    endtask

    // Keyboard model: n clock pulses, line sampled at each rising edge,
    // ACK driven low ahead of fe 11 when ack is set.
    task automatic dev_clocks(input int n, input bit ack, output logic [9:0] seen);
        seen = '1;
        repeat (HALF) tick();
        for (int k = 1; k <= n; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) tick();
            dev_clk = 1'b1;
            if (k <= 10) seen[k-1] = ps2_data_in;
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (HALF) tick();
        end
        dev_data = 1'b1;
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack, input bit jitter);
        int rts_cyc, d0, e0, g;
        logic [9:0] exp_line;
        d0 = done_cnt;
        e0 = err_cnt;
        phase_start(jitter, rts_cyc);
        dev_clocks(11, ack, last_seen);
        exp_line = line_model(b);
        n_checks++;
        if (last_seen !== exp_line) begin
            n_fail++; $display("FAIL frame(%h): got %b want %b", b, last_seen, exp_line);
        end
        g = 0;
        while (done_cnt == d0 && err_cnt == e0 && g < 40) begin tick(); g++; end
        n_checks++;
        if (done_cnt - d0 !== (ack ? 1 : 0)) begin
            n_fail++; $display("FAIL done_count(%h): got %0d want %0d", b, done_cnt - d0, ack ? 1 : 0);
        end
        n_checks++;
        if (err_cnt - e0 !== (ack ? 0 : 1)) begin
            n_fail++; $display("FAIL err_count(%h): got %0d want %0d", b, err_cnt - e0, ack ? 0 : 1);
        end
        n_checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            n_fail++; $display("FAIL end_state(%h): ready/busy/clk_oe/data_oe=%b want 1000", b, {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hAA;
        tick(); tick();
        n_checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 100000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err});
        end
        tx_valid = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err} !== 6'b100000) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 100000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err});
        end
    endtask

    task automatic test_basic();
        accept(8'hED, 1'b0);
        run_xfer(8'hED, 1'b1, 1'b0);
        n_checks++;
        if (last_seen !== 10'h3ED) begin
            n_fail++; $display("FAIL ed_frame_const: got %b want %b", last_seen, 10'h3ED);
        end
    endtask

    task automatic test_parity();
        accept(8'h01, 1'b0);
        run_xfer(8'h01, 1'b1, 1'b0);
        n_checks++;
        if (last_seen[8] !== 1'b0) begin n_fail++; $display("FAIL parity_01: got %b want 0", last_seen[8]); end
        accept(8'h00, 1'b0);
        run_xfer(8'h00, 1'b1, 1'b0);
        n_checks++;
        if (last_seen[8] !== 1'b1) begin n_fail++; $display("FAIL parity_00: got %b want 1", last_seen[8]); end
    endtask

    task automatic test_nack();
        rdy_after_err = 1'b0;
        accept(8'hF3, 1'b0);
        run_xfer(8'hF3, 1'b0, 1'b0);
        n_checks++;
        if (rdy_after_err !== 1'b1) begin n_fail++; $display("FAIL nack_ready: got %b want 1", rdy_after_err); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit ack;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            accept(b, 1'b0);
            run_xfer(b, ack, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        accept(8'hF4, 1'b1);
        tx_data = 8'hED;
        run_xfer(8'hF4, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({busy, ps2_clk_oe, tx_ready} !== 3'b110) begin
            n_fail++; $display("FAIL b2b_second_accept: busy/clk_oe/ready=%b want 110", {busy, ps2_clk_oe, tx_ready});
        end
        tx_valid = 1'b0;
        run_xfer(8'hED, 1'b1, 1'b0);
        n_checks++;
        if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int rts_cyc, d0, e0;
        logic [7:0] b;
        logic [9:0] seen;
        b = 8'($urandom);
        d0 = done_cnt;
        e0 = err_cnt;
        accept(b, 1'b0);
        phase_start(1'b0, rts_cyc);
        dev_clocks(4, 1'b0, seen);
        n_checks++;
        if (seen[3:0] !== b[3:0]) begin n_fail++; $display("FAIL mid_bits: got %b want %b", seen[3:0], b[3:0]); end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, err, tx_ready} !== 6'b000001) begin
            n_fail++; $display("FAIL mid_reset: oe/busy/done/err/ready=%b want 000001", {ps2_clk_oe, ps2_data_oe, busy, done, err, tx_ready});
        end
        rst = 1'b0;
        repeat (20) tick();
        n_checks++;
        if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin
            n_fail++; $display("FAIL mid_reset_pulses: got %0d want 0", (done_cnt - d0) + (err_cnt - e0));
        end
    endtask

    task automatic test_timeout();
        int rts_cyc, d0, e0, g;
        logic [9:0] seen;
        d0 = done_cnt;
        e0 = err_cnt;
        accept(8'($urandom), 1'b0);
        phase_start(1'b0, rts_cyc);
        dev_clocks(5, 1'b0, seen);
`ifdef PS2_TX_TIMEOUT_EN
        g = 0;
        while (err_cnt == e0 && g < TMO + 50) begin tick(); g++; end
        n_checks++;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); end
        n_checks++;
        if (err_cyc - rts_cyc !== TMO) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", err_cyc - rts_cyc, TMO); end
        n_checks++;
        if ({err_clk_oe, err_data_oe} !== 2'b00) begin n_fail++; $display("FAIL timeout_release: got %b want 00", {err_clk_oe, err_data_oe}); end
        n_checks++;
        if (done_cnt !== d0) begin n_fail++; $display("FAIL timeout_done: got %0d want %0d", done_cnt, d0); end
`else
        g = 0;
        repeat (TMO + 50) tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL no_watchdog_busy: got %b want 1", busy); end
        n_checks++;
        if (err_cnt !== e0) begin n_fail++; $display("FAIL no_watchdog_err: got %0d want %0d", err_cnt, e0); end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_nack();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        n_checks++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL done_with_err: got %0d want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
